// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issue stage in front of the 32-bit ALU.
// Buffers commands in a FIFO, drives the ALU one command at a time, returns tagged results.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cmd_*               : command valid/ready input {op, variant, a, b, ci}
//   alu_* (out)         : ALU control and operands, held from the issue register
//   alu_* (in)          : ALU result, flags, comp_result, done
//   rsp_*               : response valid/ready output {result, comp, flags, tag}
//   busy                : FSM active or FIFO holding commands
//   stat_done_cnt       : handshake counter (ALU_SEQ_STATS_EN), else 0
//   stat_timeout_cnt    : timed-out handshake counter (ALU_SEQ_STATS_EN), else 0
//
// Optional macro: ALU_SEQ_STATS_EN enables the saturating statistics counters.

module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_variant,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic             cmd_ci,
    output logic [1:0]       alu_op_sel,
    output logic [1:0]       alu_adder_sel,
    output logic             alu_sub_sel,
    output logic             alu_mult_sel,
    output logic             alu_comp_mode,
    output logic             alu_start,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_cin,
    output logic             alu_bin,
    input  logic [63:0]      alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_borrow_out,
    input  logic [5:0]       alu_comp_result,
    input  logic             alu_done,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [5:0]       rsp_comp,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      stat_done_cnt,
    output logic [15:0]      stat_timeout_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    typedef struct packed {
        logic [1:0]       op;
        logic [1:0]       variant;
        logic [31:0]      a;
        logic [31:0]      b;
        logic             ci;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MUL_START,
        S_MUL_WAIT,
        S_RESP
    } state_t;

    cmd_t             fifo_q [FIFO_DEPTH];
    cmd_t             fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    state_t           state_q, state_d;
    cmd_t             iss_q, iss_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [63:0]      rsp_result_q, rsp_result_d;
    logic [5:0]       rsp_comp_q, rsp_comp_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic full, empty;
    logic push, pop;
    logic cap, cap_to;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign busy      = (state_q != S_IDLE) || !empty;

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tag_d        = tag_q;
        state_d      = state_q;
        iss_d        = iss_q;
        set_cnt_d    = set_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_comp_d   = rsp_comp_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_tag_d    = rsp_tag_q;
        pop          = 1'b0;
        cap          = 1'b0;
        cap_to       = 1'b0;
        push         = cmd_valid && !full;

        if (push) begin
            fifo_d[wr_ptr_q].op      = cmd_op;
            fifo_d[wr_ptr_q].variant = cmd_variant;
            fifo_d[wr_ptr_q].a       = cmd_a;
            fifo_d[wr_ptr_q].b       = cmd_b;
            fifo_d[wr_ptr_q].ci      = cmd_ci;
            fifo_d[wr_ptr_q].tag     = tag_q;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            tag_d    = tag_q + TAG_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    iss_d    = fifo_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (fifo_q[rd_ptr_q].op == OP_MUL) begin
                        state_d = S_MUL_START;
                    end else begin
                        state_d   = S_SETTLE;
                        set_cnt_d = SET_W'(SETTLE_CYCLES);
                    end
                end
            end
            S_SETTLE: begin
                if (set_cnt_q == SET_W'(1)) begin
                    cap     = 1'b1;
                    cap_to  = !alu_done;
                    state_d = S_RESP;
                end else begin
                    set_cnt_d = set_cnt_q - SET_W'(1);
                end
            end
            S_MUL_START: begin
                wait_cnt_d = '0;
                state_d    = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                // done is not trusted in the first wait cycle: it may
                // still reflect the previous multiply.
                if (wait_cnt_q != '0 && alu_done) begin
                    cap     = 1'b1;
                    state_d = S_RESP;
                end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    cap     = 1'b1;
                    cap_to  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags are captured raw; the consumer interprets them per op.
        if (cap) begin
            rsp_result_d = alu_result;
            rsp_comp_d   = alu_comp_result;
            rsp_flags_d  = {cap_to, alu_overflow, alu_borrow_out, alu_carry_out};
            rsp_tag_d    = iss_q.tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tag_q        <= '0;
            state_q      <= S_IDLE;
            iss_q        <= '0;
            set_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            rsp_result_q <= '0;
            rsp_comp_q   <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tag_q        <= tag_d;
            state_q      <= state_d;
            iss_q        <= iss_d;
            set_cnt_q    <= set_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_comp_q   <= rsp_comp_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // Variant bits only reach the ALU control they belong to.
    assign alu_op_sel    = iss_q.op;
    assign alu_adder_sel = (iss_q.op == OP_ADD) ? iss_q.variant : 2'b00;
    assign alu_sub_sel   = (iss_q.op == OP_SUB) && iss_q.variant[0];
    assign alu_mult_sel  = (iss_q.op == OP_MUL) && iss_q.variant[0];
    assign alu_comp_mode = (iss_q.op == OP_CMP) && iss_q.variant[0];
    assign alu_start     = (state_q == S_MUL_START);
    assign alu_a         = iss_q.a;
    assign alu_b         = iss_q.b;
    assign alu_cin       = (iss_q.op == OP_ADD) && iss_q.ci;
    assign alu_bin       = (iss_q.op == OP_SUB) && iss_q.ci;

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_comp   = rsp_comp_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_tag    = rsp_tag_q;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_to_q, stat_to_d;

    always_comb begin
        stat_done_d = stat_done_q;
        stat_to_d   = stat_to_q;
        if (rsp_valid && rsp_ready) begin
            if (stat_done_q != 16'hFFFF) begin
                stat_done_d = stat_done_q + 16'd1;
            end
            if (rsp_flags_q[3] && stat_to_q != 16'hFFFF) begin
                stat_to_d = stat_to_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_done_q <= '0;
            stat_to_q   <= '0;
        end else begin
            stat_done_q <= stat_done_d;
            stat_to_q   <= stat_to_d;
        end
    end

    assign stat_done_cnt    = stat_done_q;
    assign stat_timeout_cnt = stat_to_q;
`else
    assign stat_done_cnt    = 16'd0;
    assign stat_timeout_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer.
// Contains a behavioural ALU model driven by the DUT's alu_* outputs.

module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_variant;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_ci;
    logic [1:0]  alu_op_sel;
    logic [1:0]  alu_adder_sel;
    logic        alu_sub_sel;
    logic        alu_mult_sel;
    logic        alu_comp_mode;
    logic        alu_start;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic        alu_bin;
    logic [63:0] alu_result;
    logic        alu_carry_out;
    logic        alu_borrow_out;
    logic [5:0]  alu_comp_result;
    logic        alu_done;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [5:0]  rsp_comp;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [15:0] stat_done_cnt;
    logic [15:0] stat_timeout_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_variant      (cmd_variant),
        .cmd_a            (cmd_a),
        .cmd_b            (cmd_b),
        .cmd_ci           (cmd_ci),
        .alu_op_sel       (alu_op_sel),
        .alu_adder_sel    (alu_adder_sel),
        .alu_sub_sel      (alu_sub_sel),
        .alu_mult_sel     (alu_mult_sel),
        .alu_comp_mode    (alu_comp_mode),
        .alu_start        (alu_start),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_cin          (alu_cin),
        .alu_bin          (alu_bin),
        .alu_result       (alu_result),
        .alu_carry_out    (alu_carry_out),
        .alu_borrow_out   (alu_borrow_out),
        .alu_comp_result  (alu_comp_result),
        .alu_done         (alu_done),
        .alu_overflow     (alu_overflow),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_comp         (rsp_comp),
        .rsp_flags        (rsp_flags),
        .rsp_tag          (rsp_tag),
        .busy             (busy),
        .stat_done_cnt    (stat_done_cnt),
        .stat_timeout_cnt (stat_timeout_cnt)
    );

    // ALU model: combinational ops report done=1; multiply raises done
    // three cycles after start unless hang is set.
    logic        hang = 1'b0;
    int          mul_cnt = 0;
    int          start_cnt = 0;
    logic [32:0] sum33;
    logic [32:0] diff33;

    always @(posedge clk) begin
        if (alu_start) begin
            mul_cnt   <= 1;
            start_cnt <= start_cnt + 1;
        end else if (mul_cnt != 0 && mul_cnt != 4) begin
            mul_cnt <= mul_cnt + 1;
        end
    end

    always_comb begin
        sum33           = '0;
        diff33          = '0;
        alu_result      = '0;
        alu_carry_out   = 1'b0;
        alu_borrow_out  = 1'b0;
        alu_overflow    = 1'b0;
        alu_comp_result = '0;
        case (alu_op_sel)
            2'b00: begin
                sum33 = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
                alu_result    = {32'd0, sum33[31:0]};
                alu_carry_out = sum33[32];
                alu_overflow  = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
            end
            2'b01: begin
                diff33 = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_bin};
                alu_result     = {32'd0, diff33[31:0]};
                alu_borrow_out = diff33[32];
            end
            2'b10: alu_result = {32'd0, alu_a} * {32'd0, alu_b};
            default: alu_comp_result = {alu_a < alu_b, alu_a > alu_b, alu_a == alu_b,
                                        alu_a <= alu_b, alu_a != alu_b, alu_a >= alu_b};
        endcase
        alu_done = (alu_op_sel != 2'b10) ? 1'b1 : (mul_cnt == 4 && !hang);
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [1:0] v,
                        input logic [31:0] a, input logic [31:0] b, input logic ci);
        int k;
        cmd_op = op; cmd_variant = v; cmd_a = a; cmd_b = b; cmd_ci = ci;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(output logic [63:0] r, output logic [5:0] c,
                            output logic [3:0] f, output logic [3:0] t, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = rsp_result; c = rsp_comp; f = rsp_flags; t = rsp_tag;
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'd0, 64'd1);
        end else begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    logic [63:0] r;
    logic [5:0]  c;
    logic [3:0]  f;
    logic [3:0]  tg;
    int          cy;
    int          sc0;
    int          acc;
    logic        rdy;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_variant = '0; cmd_a = '0; cmd_b = '0; cmd_ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_stat", {stat_done_cnt, stat_timeout_cnt}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        send(2'b00, 2'b00, 32'd100, 32'd50, 1'b0);
        wait_rsp(r, c, f, tg, cy);
        chk("add_latency", cy, 3);
        chk("add_result", r, 150);
        chk("add_flags", f, 4'b0000);
        chk("add_tag", tg, 0);

        send(2'b01, 2'b00, 32'd100, 32'd30, 1'b0);
        send(2'b11, 2'b00, 32'd100, 32'd50, 1'b0);
        wait_rsp(r, c, f, tg, cy);
        chk("sub_result", r, 70);
        chk("sub_tag", tg, 1);
        wait_rsp(r, c, f, tg, cy);
        chk("cmp_comp", c, 6'b010011);
        chk("cmp_tag", tg, 2);

        send(2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_rsp(r, c, f, tg, cy);
        chk("carry_result", r, 0);
        chk("carry_flags", f, 4'b0001);
        chk("carry_tag", tg, 3);

        send(2'b01, 2'b01, 32'd5, 32'd7, 1'b1);
        wait_rsp(r, c, f, tg, cy);
        chk("borrow_result", r, 64'h0000_0000_FFFF_FFFD);
        chk("borrow_flags", f, 4'b0010);
        chk("sub_sel_held", alu_sub_sel, 1);
        chk("bin_held", alu_bin, 1);

        send(2'b00, 2'b10, 32'h7FFF_FFFF, 32'd0, 1'b1);
        wait_rsp(r, c, f, tg, cy);
        chk("ovf_result", r, 64'h8000_0000);
        chk("ovf_flags", f, 4'b0100);
        chk("cin_held", alu_cin, 1);
        chk("bin_forced", alu_bin, 0);
        chk("adder_sel_held", alu_adder_sel, 2'b10);

        sc0 = start_cnt;
        send(2'b10, 2'b01, 32'd20, 32'd15, 1'b0);
        wait_rsp(r, c, f, tg, cy);
        chk("mul_result", r, 300);
        chk("mul_flags", f, 4'b0000);
        chk("mul_tag", tg, 6);
        chk("mul_latency", cy, 6);
        chk("mul_starts", start_cnt - sc0, 1);
        chk("mult_sel_held", alu_mult_sel, 1);
        chk("cin_forced_mul", alu_cin, 0);

        hang = 1'b1;
        send(2'b10, 2'b00, 32'd3, 32'd4, 1'b0);
        wait_rsp(r, c, f, tg, cy);
        chk("to_latency", cy, 66);
        chk("to_flags", f, 4'b1000);
        chk("to_result", r, 12);
        chk("to_tag", tg, 7);
`ifdef ALU_SEQ_STATS_EN
        chk("stat_done", stat_done_cnt, 8);
        chk("stat_timeout", stat_timeout_cnt, 1);
`else
        chk("stat_done_tied", stat_done_cnt, 0);
        chk("stat_timeout_tied", stat_timeout_cnt, 0);
`endif
        hang = 1'b0;

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_op = 2'b00; cmd_variant = 2'b00; cmd_ci = 1'b0;
            cmd_a = 32'(acc * 10); cmd_b = 32'd1;
            cmd_valid = 1'b1;
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_rsp_held", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(r, c, f, tg, cy);
            chk("bp_tag", tg, 64'(i));
            chk("bp_result", r, 64'(i * 10 + 1));
        end
        chk("bp_ready_back", cmd_ready, 1);
        chk("bp_idle", busy, 0);

        hang = 1'b1;
        send(2'b10, 2'b00, 32'd2, 32'd2, 1'b0);
        send(2'b00, 2'b00, 32'd1, 32'd1, 1'b0);
        send(2'b00, 2'b00, 32'd2, 32'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hang = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        send(2'b00, 2'b00, 32'd7, 32'd8, 1'b0);
        wait_rsp(r, c, f, tg, cy);
        chk("post_rst_tag", tg, 0);
        chk("post_rst_result", r, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 32-bit ALU. Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU control and operand inputs one command at a time. Combinational ops (add, sub, compare) get a fixed settle window. Multiply gets a one-cycle `start` pulse and a `done` wait with timeout.
- Returns the captured result, flags and a sequence tag over a valid/ready response interface.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; must be a power of 2, ≥2.
- SETTLE_CYCLES, 2: cycles the ALU inputs are held before capture for op 00/01/11; ≥1.
- TIMEOUT_CYCLES, 64: maximum cycles in multiply wait before forced capture.
- TAG_W, 4: width of the sequence tag.

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  = FIFO not full
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 compare
- cmd_variant  in  2  add: adder_sel; sub: bit0 = sub_sel; mul: bit0 = mult_sel; cmp: bit0 = comp_mode
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_ci  in  1  cin for add, bin for sub; ignored otherwise
- alu_op_sel  out  2  to ALU op_sel
- alu_adder_sel  out  2  to ALU adder_sel
- alu_sub_sel  out  1  to ALU sub_sel
- alu_mult_sel  out  1  to ALU mult_sel
- alu_comp_mode  out  1  to ALU comp_mode
- alu_start  out  1  to ALU start
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_cin  out  1  to ALU cin
- alu_bin  out  1  to ALU bin
- alu_result  in  64  from ALU result
- alu_carry_out  in  1  from ALU carry_out
- alu_borrow_out  in  1  from ALU borrow_out
- alu_comp_result  in  6  from ALU comp_result
- alu_done  in  1  from ALU done
- alu_overflow  in  1  from ALU overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  64  captured result
- rsp_comp  out  6  captured comp_result
- rsp_flags  out  4  {timeout, overflow, borrow, carry}
- rsp_tag  out  TAG_W  tag of the command
- busy  out  1  FSM not IDLE or FIFO not empty
- stat_done_cnt  out  16  see Optional Feature
- stat_timeout_cnt  out  16  see Optional Feature

Behaviour:
- Reset
  - FIFO emptied; FSM to IDLE; tag counter to 0.
  - All outputs 0, except cmd_ready = 1.
  - Reset mid-operation abandons any in-flight command and any pending response; no response is produced for it.
- FIFO
  - Push on cmd_valid && cmd_ready. The entry stores {op, variant, a, b, ci, tag}; tag counter increments mod 2^TAG_W on each push.
  - cmd_ready = !full, with no same-cycle pop bypass when full.
  - Pointers wrap mod FIFO_DEPTH.
- FSM states: IDLE, SETTLE, MUL_START, MUL_WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head into the issue register, which drives all alu_* outputs.
    - op≠10 → SETTLE with cnt = SETTLE_CYCLES.
    - op=10 → MUL_START.
  - SETTLE: cnt decrements each cycle. On the cnt==1 edge, capture rsp_* from alu_* inputs → RESP.
    - timeout flag = !alu_done at capture.
  - MUL_START: alu_start = 1 for exactly this cycle; wait counter cleared → MUL_WAIT.
  - MUL_WAIT: alu_start = 0; counter increments each cycle.
    - alu_done is ignored in the first MUL_WAIT cycle.
    - On alu_done=1 thereafter: capture → RESP with timeout=0.
    - If counter reaches TIMEOUT_CYCLES first: capture current alu_result → RESP with timeout=1.
  - RESP: rsp_valid = 1 with rsp_* stable until rsp_ready; on the handshake edge → IDLE. No back-to-back bypass, so the minimum spacing between responses is 1 IDLE cycle.
- Output holding
  - alu_* outputs hold the last issued command while IDLE.
  - alu_cin and alu_bin are both forced 0 unless op is 00 (cin) or 01 (bin), respectively.
- Unused captures
  - rsp_comp is captured for every op.
  - carry, borrow and overflow are captured raw, with no masking by op.
- Latency: with the FIFO empty and the FSM idle, a command accepted at edge E yields rsp_valid at edge E+1+SETTLE_CYCLES for combinational ops.
- Ordering: responses are issued strictly in command order; tags are consecutive.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined:
  - stat_done_cnt increments on each response handshake.
  - stat_timeout_cnt increments on each handshake with timeout=1.
  - Both counters are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Add: op 00, variant 00, a=100, b=50, ci=0 → rsp_result[31:0]=150, carry=0, tag=0; rsp_valid exactly 3 cycles after acceptance (SETTLE=2).
- Sub then compare back-to-back: (op 01, a=100, b=30) then (op 11, variant 0, a=100, b=50) → results 70 (tag 1) and rsp_comp=6'b010011 (tag 2), in order.
- Multiply: op 10, a=20, b=15 → exactly one alu_start pulse; rsp_result=300, timeout=0.
- Backpressure: rsp_ready=0, issue 8 commands → 5 accepted (1 in flight + 4 queued), cmd_ready low. Release rsp_ready → all 5 responses drain with tags 0–4, then cmd_ready returns high.
- Timeout: model holds alu_done=0 on multiply → rsp after 64 MUL_WAIT cycles with rsp_flags[3]=1. With ALU_SEQ_STATS_EN: stat_timeout_cnt=1.
- Reset mid-MUL_WAIT with 2 commands queued → next cycle busy=0, rsp_valid=0, cmd_ready=1; the next command gets tag 0.
